mem_bist_master: RTL
====================

MEM_BIST_MASTER -- requirements
Module: mem_bist_master

Interface
REQ-001 Parameter: SEED, default 16'hA5C3, base test pattern.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  test request; sampled only in IDLE.
REQ-005 busy  output  1  high while in WRITE or READ.
REQ-006 done  output  1  one-cycle completion pulse.
REQ-007 pass  output  1  1 = last run had zero mismatches; held until next accepted start.
REQ-008 err_count  output  3  mismatches in current/last run; saturates at 7.
REQ-009 err_addr  output  2  address of first mismatch in current/last run.
REQ-010 addr  output  2  bus address to the 4x16 register slave.
REQ-011 wr  output  1  bus write strobe.
REQ-012 sel  output  1  bus select.
REQ-013 wdata  output  16  bus write data.
REQ-014 rdata  input  16  bus read data; combinational from the slave and valid in the same cycle as sel=1, wr=0.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States SHALL be IDLE, WRITE, READ and DONE.
REQ-017 Pattern SHALL be pat(a) = SEED ^ {8{a}}: a=0 A5C3, a=1 F096, a=2 0F69, a=3 5A3C.
REQ-018 IDLE: sel=0, wr=0, addr=0, wdata=0.
REQ-019 IDLE with start=1 at an edge:
  - go to WRITE; drive addr=0, sel=1, wr=1, wdata=exp(0) from that edge;
  - clear err_count, err_addr, pass and pass index.
REQ-020 WRITE: one write per cycle, addr 0,1,2,3. After addr=3: go to READ with addr=0, sel=1, wr=0, wdata=0.
REQ-021 READ: one read per cycle, addr 0..3. At each edge, compare rdata with exp(addr).
  - mismatch: err_count increments, saturating at 7;
  - err_addr latches addr only on the first mismatch of the run.
REQ-022 After the addr=3 read: go to DONE, unless REQ-029 applies.
REQ-023 DONE (one cycle):
  - sel=0, wr=0, done=1, pass=(final err_count==0);
  - then go to IDLE.
REQ-024 start is ignored in WRITE, READ and DONE; no queuing.
REQ-025 Latency: done is high in the cycle starting 8 edges after the start-accept edge (16 with REQ-029). A new start is accepted no earlier than the cycle after done.
REQ-026 rdata is never sampled when sel=0 or wr=1.

Reset
REQ-027 rstn=0 at an edge SHALL force IDLE and set busy, done, pass, err_count, err_addr, addr, wr, sel, wdata to 0, including mid-run. The aborted run SHALL produce no done pulse.

Configuration
REQ-028 Macro MEM_BIST_INV_PASS_EN selects one or two passes.
REQ-029 With the macro defined:
  - after the first READ sweep, go to WRITE with pass index 1;
  - pass 1 SHALL use exp(a) = ~pat(a) (5A3C, 0F69, F096, A5C3);
  - errors accumulate across both passes; DONE follows the second READ sweep.
REQ-030 Without the macro: single pass with exp(a) = pat(a); no pass-index logic is generated.

Verification
REQ-031 Clean run: behavioural 4x16 slave, start pulse -> writes A5C3/F096/0F69/5A3C to addr 0..3, then 4 reads; done at edge +8; pass=1, err_count=0.
REQ-032 Single fault: slave returns 0000 on read of addr 1 -> err_count=1, err_addr=1, pass=0.
REQ-033 Multiple faults: slave rdata stuck at FFFF for all reads -> err_count=4, err_addr=0, pass=0. With the macro: addr 0 still fails in pass 1 (expected 5A3C), err_count=7 (saturated), err_addr=0.
REQ-034 Start while busy: start held high for 20 cycles -> exactly one run per done, new run begins in the cycle after done, err_count cleared at re-accept.
REQ-035 Reset mid-run: rstn=0 during the READ of addr 2 -> next cycle all outputs 0, state IDLE, no done; a following start completes normally with pass=1.
REQ-036 Macro defined, clean slave -> 8 writes and 8 reads; pass-1 write data 5A3C/0F69/F096/A5C3; done at edge +16; pass=1.

Source files
------------

// File: rtl/mem_bist_if.sv
// Bus between the BIST master and a 4x16 register slave.
// rdata is combinational from the slave, valid while sel=1 and wr=0.
interface mem_bist_if;
  logic [1:0]  addr;
  logic        wr;
  logic        sel;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output addr, wr, sel, wdata, input rdata);
  modport slave  (input addr, wr, sel, wdata, output rdata);
endinterface

// File: rtl/mem_bist_master.sv
// Write/read-back BIST master for a 4x16 register slave; all outputs registered.
// Define MEM_BIST_INV_PASS_EN to add a second, inverted-pattern pass.
module mem_bist_master #(
  parameter logic [15:0] SEED = 16'hA5C3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_count,
  output logic [1:0]  err_addr,
  mem_bist_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [2:0]  err_count_q, err_count_d;
  logic [1:0]  err_addr_q, err_addr_d;
  logic [1:0]  addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        sel_q, sel_d;
  logic [15:0] wdata_q, wdata_d;
  logic        cur_inv;

`ifdef MEM_BIST_INV_PASS_EN
  logic pidx_q, pidx_d;
  assign cur_inv = pidx_q;
`else
  assign cur_inv = 1'b0;
`endif

  // Expected word: SEED ^ {8{a}}, bitwise inverted on the second pass.
  function automatic logic [15:0] exp_data(input logic [1:0] a, input logic inv);
    return (SEED ^ {8{a}}) ^ {16{inv}};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    addr_d      = 2'd0;
    wr_d        = 1'b0;
    sel_d       = 1'b0;
    wdata_d     = 16'h0000;
`ifdef MEM_BIST_INV_PASS_EN
    pidx_d      = pidx_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WRITE;
          busy_d      = 1'b1;
          sel_d       = 1'b1;
          wr_d        = 1'b1;
          wdata_d     = exp_data(2'd0, 1'b0);
          err_count_d = 3'd0;
          err_addr_d  = 2'd0;
          pass_d      = 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
          pidx_d      = 1'b0;
`endif
        end
      end

      WRITE: begin
        busy_d = 1'b1;
        sel_d  = 1'b1;
        if (addr_q == 2'd3) begin
          state_d = READ;
        end else begin
          wr_d    = 1'b1;
          addr_d  = addr_q + 2'd1;
          wdata_d = exp_data(addr_q + 2'd1, cur_inv);
        end
      end

      READ: begin
        // Only reached with sel=1, wr=0 on the bus, so rdata is valid here.
        if (bus.rdata != exp_data(addr_q, cur_inv)) begin
          if (err_count_q != 3'd7) err_count_d = err_count_q + 3'd1;
          if (err_count_q == 3'd0) err_addr_d = addr_q;
        end
        if (addr_q != 2'd3) begin
          busy_d = 1'b1;
          sel_d  = 1'b1;
          addr_d = addr_q + 2'd1;
        end
`ifdef MEM_BIST_INV_PASS_EN
        else if (!pidx_q) begin
          state_d = WRITE;
          pidx_d  = 1'b1;
          busy_d  = 1'b1;
          sel_d   = 1'b1;
          wr_d    = 1'b1;
          wdata_d = exp_data(2'd0, 1'b1);
        end
`endif
        else begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 3'd0);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the reset is synchronous (sampled only on clk), and sequential state uses <= so all flops update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      err_addr_q  <= 2'd0;
      addr_q      <= 2'd0;
      wr_q        <= 1'b0;
      sel_q       <= 1'b0;
      wdata_q     <= 16'h0000;
`ifdef MEM_BIST_INV_PASS_EN
      pidx_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
`ifdef MEM_BIST_INV_PASS_EN
      pidx_q      <= pidx_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
  assign bus.addr  = addr_q;
  assign bus.wr    = wr_q;
  assign bus.sel   = sel_q;
  assign bus.wdata = wdata_q;

endmodule
